// File: rtl/mem_access_unit.sv
// Memory access sequencer: req/ready/rvalid handshake to a variable-latency memory,
// store byte enables with lane replication, load lane select with sign/zero extension.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_fetch,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_e;

    state_e                state_q, state_d;
    logic                  store_q, store_d;
    logic                  fetch_q, fetch_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            lane_q, lane_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           rdata_q, rdata_d;

    logic        illegal;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    // Legality and store lane shaping are judged on the raw request, before latching.
    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned (no latch).
        illegal     = 1'b0;
        store_be    = 4'b1111;
        store_wdata = wdata;
        if (is_fetch) begin
            illegal = (addr[1:0] != 2'b00);
        end else begin
            case (funct3)
                3'b000, 3'b100: illegal = 1'b0;
                3'b001, 3'b101: illegal = addr[0];
                3'b010:         illegal = (addr[1:0] != 2'b00);
                default:        illegal = 1'b1;
            endcase
        end
        case (funct3[1:0])
            2'b00: begin
                store_be    = 4'b0001 << addr[1:0];
                store_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                store_be    = addr[1] ? 4'b1100 : 4'b0011;
                store_wdata = {2{wdata[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        rd_byte = 8'(mem_rdata >> {lane_q, 3'b000});
        rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        rd_ext  = mem_rdata;
        if (!fetch_q) begin
            case (f3_q)
                3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
                3'b100:  rd_ext = {24'b0, rd_byte};
                3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
                3'b101:  rd_ext = {16'b0, rd_half};
                default: rd_ext = mem_rdata;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        fetch_d     = fetch_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    store_d     = is_store & ~is_fetch;
                    fetch_d     = is_fetch;
                    f3_d        = funct3;
                    lane_d      = addr[1:0];
                    mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_be_d    = (is_store && !is_fetch) ? store_be : 4'b1111;
                    mem_wdata_d = store_wdata;
                    state_d     = illegal ? S_FAULT : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready) state_d = store_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = rd_ext;
                    state_d = S_DONE;
                end
            end
            S_DONE, S_FAULT: state_d = S_IDLE;
            default:         state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            store_q     <= 1'b0;
            fetch_q     <= 1'b0;
            f3_q        <= 3'b000;
            lane_q      <= 2'b00;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'b0;
            rdata_q     <= 32'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            store_q     <= store_d;
            fetch_q     <= fetch_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Handshake outputs decode the state directly, so reset drops them without waiting for a clock.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE) || (state_q == S_FAULT);
    assign fault     = (state_q == S_FAULT);
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = (state_q == S_REQ) && store_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// checked against an arithmetic reference model of sizes, lanes and extension.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_fetch = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'b0;
    logic [31:0] wdata = 32'b0;
    logic [31:0] rdata;
    logic        busy, done, fault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] model_rdata = 32'b0;
    logic [2:0]  load_codes [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [2:0]  store_codes [4] = '{3'd0, 3'd1, 3'd2, 3'd3};

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_fetch(is_fetch), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic int access_size(input logic f, input logic [2:0] f3);
        if (f) return 4;
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_fault(input logic f, input logic [2:0] f3, input logic [31:0] a);
        if (!f && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        return (int'(a[1:0]) % access_size(f, f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        if (!st) return 4'hF;
        sz = access_size(1'b0, f3);
        return 4'(((1 << sz) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        logic [31:0] res;
        sz  = access_size(1'b0, f3);
        res = 32'b0;
        for (int i = 0; i < 4; i++)
            res = res | (((wd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        return res;
    endfunction

    function automatic logic [31:0] model_load(input logic f, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] rw);
        int sz;
        logic [63:0] mask, v;
        if (f) return rw;
        sz   = access_size(1'b0, f3);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        v    = ({32'b0, rw} >> (8 * int'(a[1:0]))) & mask;
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic do_access(input string tag, input logic f, input logic s, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                             input int rdly, input int vdly, input logic stray);
        logic ef, is_st, accepted, ready_on, req_prev, rv_done, fin, do_stray;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        int exp_lat, done_at, done_cnt, rq, wc;
        is_st    = s && !f;
        ef       = model_fault(f, f3, a);
        ebe      = model_be(is_st, f3, a);
        ewd      = model_wdata(f3, wd);
        exp_lat  = ef ? 1 : (is_st ? 2 + rdly : 3 + rdly + vdly);
        do_stray = stray && !ef;
        if (!ef && !is_st) model_rdata = model_load(f, f3, a, rw);
        accepted = 0; ready_on = 0; req_prev = 0; rv_done = 0; fin = 0;
        done_at = 0; done_cnt = 0; rq = 0; wc = 0;

        @(negedge clk);
        start = 1'b1; is_fetch = f; is_store = s; funct3 = f3; addr = a; wdata = wd;
        for (int c = 1; c <= 60 && !fin; c++) begin
            @(negedge clk);
            if (ready_on && req_prev) accepted = 1'b1;
            if (done_at > 0) begin
                check({tag, "_busy_after"}, 32'(busy), 32'd0);
                check({tag, "_done_after"}, 32'(done), 32'd0);
                fin = 1'b1;
            end else begin
                check({tag, "_req"}, 32'(mem_req), 32'(!ef && !accepted));
                if (mem_req) begin
                    check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
                    check({tag, "_be"}, 32'(mem_be), 32'(ebe));
                    check({tag, "_we"}, 32'(mem_we), 32'(is_st));
                    if (is_st) check({tag, "_wdata"}, mem_wdata, ewd);
                end
                if (done) begin
                    done_at = c;
                    check({tag, "_latency"}, 32'(c), 32'(exp_lat));
                    check({tag, "_fault"}, 32'(fault), 32'(ef));
                    check({tag, "_busy_done"}, 32'(busy), 32'd1);
                    check({tag, "_rdata"}, rdata, model_rdata);
                end
            end
            if (done) done_cnt++;
            req_prev = mem_req;

            // Scramble request inputs after the start cycle; the design must use latched copies.
            start    = do_stray && (c == 2);
            is_fetch = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
            addr     = $urandom; wdata = $urandom;
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom; ready_on = 1'b0;
            if (mem_req && !accepted) begin
                mem_ready  = (rq == rdly);
                ready_on   = mem_ready;
                mem_rvalid = 1'($urandom);
                rq++;
            end else if (accepted && !is_st && !rv_done && done_at == 0) begin
                if (wc == vdly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rw;
                    rv_done    = 1'b1;
                end
                wc++;
            end
        end
        check({tag, "_complete"}, 32'(fin), 32'd1);
        check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        start = 1'b0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check({tag, "_rdata_idle"}, rdata, model_rdata);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        do_access("fetch", 1, 0, 3'd2, 32'h10, 32'h0, 32'h0010_0093, 0, 0, 0);
        check("fetch_lit", rdata, 32'h0010_0093);
        do_access("lb", 0, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0);
        check("lb_lit", rdata, 32'hFFFF_FF80);
        do_access("lbu", 0, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 1, 2, 0);
        check("lbu_lit", rdata, 32'h0000_0080);
        do_access("lhu", 0, 0, 3'd5, 32'h102, 32'h0, 32'h80FF_1234, 0, 1, 0);
        check("lhu_lit", rdata, 32'h0000_80FF);
        do_access("sb", 0, 1, 3'd0, 32'h201, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
        do_access("sh", 0, 1, 3'd1, 32'h202, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
        do_access("lw_mis", 0, 0, 3'd2, 32'h302, 32'h0, 32'h1234_5678, 0, 0, 0);
        check("lw_mis_lit", rdata, 32'h0000_80FF);
        do_access("sh_mis", 0, 1, 3'd1, 32'h301, 32'h1111_2222, 32'h0, 0, 0, 0);
        do_access("sw_slow", 0, 1, 3'd2, 32'h404, 32'hCAFE_F00D, 32'h0, 3, 0, 1);
        do_access("lh_slow", 0, 0, 3'd1, 32'h502, 32'h0, 32'h9ABC_0000, 3, 2, 1);
        check("lh_slow_lit", rdata, 32'hFFFF_9ABC);

        // Reset while waiting for read data.
        @(negedge clk);
        start = 1'b1; is_fetch = 1'b0; is_store = 1'b0; funct3 = 3'd2; addr = 32'h600;
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rst_wait_busy", 32'(busy), 32'd1);
        check("rst_wait_req", 32'(mem_req), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        model_rdata = 32'b0;
        @(negedge clk);
        reset = 1'b1;
        do_access("lw_post", 0, 0, 3'd2, 32'h700, 32'h0, 32'h1357_9BDF, 1, 1, 0);
        check("lw_post_lit", rdata, 32'h1357_9BDF);

        for (int i = 0; i < 80; i++) begin
            logic f, s;
            logic [2:0]  f3;
            logic [31:0] a;
            f = ($urandom % 5) == 0;
            s = 1'($urandom);
            if (s) f3 = store_codes[$urandom % 4];
            else if ($urandom % 8 == 0) f3 = load_codes[5 + ($urandom % 3)];
            else f3 = load_codes[$urandom % 5];
            a = $urandom;
            if ($urandom % 2) a[1:0] = 2'b00;
            do_access("rnd", f, s, f3, a, $urandom, $urandom,
                      int'($urandom % 4), int'($urandom % 4), ($urandom % 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
